sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Parametrised single-clock synchronous FIFO. It is the successor to the fixed 8-bit x 16-entry FIFO and generalises data width and depth. It adds occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain and is driven and monitored through the existing driver/input-monitor/output-monitor interface style.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
PTR_W, $clog2(DEPTH), pointer width (derived, not overridden)
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-low reset
wr_en  input  1  write request
rd_en  input  1  read request
data_in  input  DATA_W  write data
data_out  output  DATA_W  read data (registered)
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  PTR_W+1  current occupancy, 0..DEPTH
wr_ptr  output  PTR_W  write address (debug/monitor)
rd_ptr  output  PTR_W  read address (debug/monitor)
overflow  output  1  sticky: write attempted while full and not accepted
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset: one clock and active-low synchronous. rst==0 sampled at posedge clears wr_ptr, rd_ptr, count, data_out, overflow and underflow to 0. It sets empty=1 and almost_empty=1, and clears full=0 and almost_full=0 (for legal thresholds). Memory contents are not cleared. Reset mid-operation discards all stored data and takes effect at that edge. wr_en and rd_en are ignored while rst==0.
- Write accept: wr_en && (!full || rd_en). The accepted write stores data_in at mem[wr_ptr], and wr_ptr increments modulo DEPTH (natural wrap).
- Read accept: rd_en && !empty. data_out <= mem[rd_ptr] on the same edge, so data is valid in the cycle after the rd_en edge (latency 1). rd_ptr increments modulo DEPTH. With no accepted read, data_out holds its value.
- Simultaneous read and write:
  - Not empty: both are accepted and count is unchanged.
  - Full: the read frees a slot, so the write is also accepted. count stays DEPTH and there is no overflow.
  - Empty: the write is accepted and the read is rejected. underflow is set, count goes 0->1, and data_out holds.
- count: +1 on write-only accept, -1 on read-only accept, else unchanged.
- Flags full, empty, almost_full and almost_empty are decoded combinationally from registered count, so they are glitch-free relative to clk.
- overflow: set when wr_en && full && !rd_en; the write is dropped and the FIFO is unchanged. underflow: set when rd_en && empty. Both stay set until reset.
- Elaboration check: AF_THRESH in 1..DEPTH and AE_THRESH in 0..DEPTH-1, else $error.

Optional Feature:
FIFO_FWFT_EN
- Defined: first-word-fall-through.
  - data_out always presents mem[rd_ptr] when !empty, with no read latency; rd_en acts as a pop/acknowledge.
  - Data written into an empty FIFO appears on data_out one cycle after the write edge.
  - When empty, data_out holds its last value.
- Undefined: standard mode as specified in Behaviour, with registered data_out and 1-cycle latency.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then release -> empty=1, almost_empty=1, full=0, count=0, data_out=0, overflow=underflow=0.
- Fill/drain, DEPTH=16: write 0x00..0x0F on consecutive cycles -> full=1 and count=16 after the 16th write, and almost_full=1 at count=14. Then read 16 -> data_out 0x00..0x0F in order, one cycle after each rd_en, and empty=1 at the end.
- Overflow: full FIFO with wr_en=1, rd_en=0, data_in=0xAA -> overflow=1 sticky, count=16, and 0xAA never read out. Same case with rd_en=1 -> overflow stays 0, and 0xAA is read as the 16th subsequent word.
- Underflow/simultaneous on empty: empty FIFO with wr_en=rd_en=1, data_in=0x5C -> underflow=1, count=1, data_out unchanged. The next read returns 0x5C.
- Wrap-around: 40 cycles of random interleaved writes and reads, keeping count between 1 and 15 -> pointers wrap 15->0 without data corruption, and a scoreboard matches all words.
- Reset mid-operation: count=9, drive rst=0 for one edge with wr_en=1 -> count=0, empty=1, pointers 0, and the write is ignored.

Source files
------------

// File: rtl/sync_fifo_param.sv
`default_nettype none
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, almost flags and sticky errors. Rev 1.0
// Define FIFO_FWFT_EN for first-word-fall-through output; the default build uses registered read data.
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [PTR_W:0]    count,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W:0]   C_DEPTH   = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   C_AF      = (PTR_W + 1)'(AF_THRESH);
  localparam logic [PTR_W:0]   C_AE      = (PTR_W + 1)'(AE_THRESH);
  localparam logic [PTR_W:0]   C_CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);

  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH) || (AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_thresh
    $error("sync_fifo_param: AF_THRESH must be 1..DEPTH and AE_THRESH 0..DEPTH-1");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_acc, rd_acc;

  assign full         = (count_q == C_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= C_AF);
  assign almost_empty = (count_q <= C_AE);

  // A read on a full FIFO frees a slot, so a simultaneous write is still accepted.
  assign wr_acc = wr_en && (!full || rd_en);
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_acc ? (wr_ptr_q + C_PTR_ONE) : wr_ptr_q;
    rd_ptr_d = rd_acc ? (rd_ptr_q + C_PTR_ONE) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (wr_en && full && !rd_en);
    udf_d = udf_q | (rd_en && empty);
`ifdef FIFO_FWFT_EN
    dout_d = empty ? dout_q : mem_q[rd_ptr_q];
`else
    dout_d = rd_acc ? mem_q[rd_ptr_q] : dout_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst && wr_acc) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty ? dout_q : mem_q[rd_ptr_q];
`else
  assign data_out = dout_q;
`endif

  assign count     = count_q;
  assign wr_ptr    = wr_ptr_q;
  assign rd_ptr    = rd_ptr_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// tb_sync_fifo_param: directed scoreboard bench for sync_fifo_param (DATA_W=8, DEPTH=16, standard read mode).
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic [3:0] wr_ptr, rd_ptr;
  logic       overflow, underflow;

  sync_fifo_param dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .data_in      (data_in),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mq [$];
  logic [7:0] exp_q [$];
  logic [3:0] m_wp, m_rp;
  logic [7:0] m_dout;
  logic       m_ovf, m_udf;
  logic       rd_mark = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    int sz;
    sz = mq.size();
    chk("count",        32'(count),        32'(sz));
    chk("full",         32'(full),         32'(sz == 16));
    chk("empty",        32'(empty),        32'(sz == 0));
    chk("almost_full",  32'(almost_full),  32'(sz >= 14));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= 2));
    chk("wr_ptr",       32'(wr_ptr),       32'(m_wp));
    chk("rd_ptr",       32'(rd_ptr),       32'(m_rp));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_udf));
    chk("data_out",     32'(data_out),     32'(m_dout));
  endtask

  // Monitor: one cycle after an accepted read edge, compare data_out with the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      if (rd_mark) begin
        #1;
        if (exp_q.size() == 0) begin
          chk("scoreboard_underrun", 32'd1, 32'd0);
        end else begin
          chk("read_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic do_reset(input int ncyc, input logic w);
    rst     = 1'b0;
    wr_en   = w;
    rd_en   = 1'b0;
    data_in = 8'hEE;
    rd_mark = 1'b0;
    repeat (ncyc) @(posedge clk);
    @(negedge clk);
    rst   = 1'b1;
    wr_en = 1'b0;
    mq.delete();
    exp_q.delete();
    m_wp = '0; m_rp = '0; m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    check_state();
  endtask

  // Drive one cycle from a negedge, advance the model, and check the state at the next negedge.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    logic m_full, m_empty, wacc, racc;
    m_full  = (mq.size() == 16);
    m_empty = (mq.size() == 0);
    wacc    = w && (!m_full || r);
    racc    = r && !m_empty;
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    rd_mark = racc;
    if (racc) begin
      m_dout = mq.pop_front();
      exp_q.push_back(m_dout);
      m_rp++;
    end
    if (wacc) begin
      mq.push_back(d);
      m_wp++;
    end
    if (w && m_full && !r) m_ovf = 1'b1;
    if (r && m_empty)      m_udf = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    rd_mark = 1'b0;
    check_state();
  endtask

  initial begin
    logic w, r;
    do_reset(2, 1'b0);

    // Fill 0x00..0x0F then drain in order.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);

    // Full with simultaneous read: 0xAA accepted, comes out as the 16th word.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i));
    cyc(1'b1, 1'b1, 8'hAA);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);

    // Full without read: 0xAA dropped, overflow sticky.
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
    cyc(1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, 8'h00);

    // Empty with simultaneous write and read.
    do_reset(1, 1'b0);
    cyc(1'b1, 1'b1, 8'h5C);
    cyc(1'b0, 1'b1, 8'h00);

    // Interleaved traffic, occupancy kept within 1..15, pointers wrap.
    cyc(1'b1, 1'b0, 8'h77);
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (mq.size() <= 1 && r && !w) r = 1'b0;
      if (mq.size() >= 15 && w && !r) w = 1'b0;
      cyc(w, r, 8'($urandom_range(0, 255)));
    end
    while (mq.size() > 0) cyc(1'b0, 1'b1, 8'h00);

    // Reset mid-operation with a write pending.
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
    chk("count_before_reset", 32'(count), 32'd9);
    do_reset(1, 1'b1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
